// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder and its store buffer.
package dmem_responder_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefSbDepth = 4;
  localparam int unsigned DataW      = 32;
  // Width of one store-buffer record: {word index, data}.
  localparam int unsigned SbEntryW   = DefAddrW + DataW;

  // Word accesses must have the two low byte-address bits clear.
  function automatic logic is_aligned(logic [1:0] byte_lo);
    return byte_lo == 2'b00;
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer: FIFO of {word index, data} records with a parallel
// lookup that returns the youngest entry matching a word index.
module store_buffer
  import dmem_responder_pkg::*;
#(
  parameter int unsigned AddrW  = DefAddrW,
  parameter int unsigned Depth  = DefSbDepth,
  parameter int unsigned EntryW = SbEntryW
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [AddrW-1:0]           push_idx_i,
  input  logic [DataW-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [AddrW-1:0]           pop_idx_o,
  output logic [DataW-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o,
  input  logic [AddrW-1:0]           lookup_idx_i,
  output logic                       hit_o,
  output logic [DataW-1:0]           hit_data_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [EntryW-1:0] entry_q [Depth];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW:0]     head_q, head_d, tail_q, tail_d;
  logic              push_ok, pop_ok;
  logic [PtrW:0]     slot;

  assign count_o = tail_q - head_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (PtrW+1)'(Depth));

  // A push into a full buffer is only accepted when the same edge pops.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  assign {pop_idx_o, pop_data_o} = entry_q[head_q[PtrW-1:0]];

  // Next-state pointer advance for push and pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (push_ok) tail_d = tail_q + (PtrW+1)'(1);
    if (pop_ok)  head_d = head_q + (PtrW+1)'(1);
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage; contents need no reset since occupancy gates their use.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_ok) begin
      entry_q[tail_q[PtrW-1:0]] <= {push_idx_i, push_data_i};
    end
  end

  // Scan oldest to youngest so the last (youngest) match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    slot       = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      slot = head_q + (PtrW+1)'(i);
      if (((PtrW+1)'(i) < count_o) &&
          (entry_q[slot[PtrW-1:0]][EntryW-1:DataW] == lookup_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entry_q[slot[PtrW-1:0]][DataW-1:0];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// M-stage data memory: word RAM fronted by a store buffer. Stores are queued
// and drained into the RAM in cycles without a load; loads forward from the
// buffer when a pending store matches.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned SB_DEPTH = DefSbDepth
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        memreadM,
  input  logic                        memwriteM,
  input  logic [31:0]                 aluoutM,
  input  logic [31:0]                 writedataM,
  output logic [31:0]                 readdataM,
  output logic                        addr_errorM,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);

  logic [DataW-1:0]  ram_q [2**ADDR_W];
  logic [ADDR_W-1:0] word_idx;
  logic              aligned;
  logic              load_en;
  logic              sb_push, sb_pop;
  logic              sb_full, sb_empty;
  logic [ADDR_W-1:0] pop_idx;
  logic [DataW-1:0]  pop_data;
  logic              hit;
  logic [DataW-1:0]  hit_data;
  logic              unused_addr_hi;

  // Upper address bits are ignored so accesses wrap modulo the RAM size.
  assign word_idx       = aluoutM[ADDR_W+1:2];
  assign unused_addr_hi = ^aluoutM[31:ADDR_W+2];
  assign aligned        = is_aligned(aluoutM[1:0]);

  assign addr_errorM = (memreadM | memwriteM) & ~aligned;
  // A simultaneous store wins; the load half is dropped.
  assign load_en     = memreadM & ~memwriteM & aligned;

  assign sb_push = rst & memwriteM & aligned;
  // Drain when no load is using the RAM port, or when forced to make room.
  assign sb_pop  = rst & ~sb_empty & (~memreadM | (sb_push & sb_full));

  store_buffer #(
    .AddrW  (ADDR_W),
    .Depth  (SB_DEPTH),
    .EntryW (ADDR_W + DataW)
  ) u_store_buffer (
    .clk_i        (clk),
    .rst_ni       (rst),
    .push_i       (sb_push),
    .push_idx_i   (word_idx),
    .push_data_i  (writedataM),
    .pop_i        (sb_pop),
    .pop_idx_o    (pop_idx),
    .pop_data_o   (pop_data),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .count_o      (sb_count),
    .lookup_idx_i (word_idx),
    .hit_o        (hit),
    .hit_data_o   (hit_data)
  );

  // RAM write port fed only by store-buffer drains; never reset.
  always_ff @(posedge clk) begin
    if (sb_pop) begin
      ram_q[pop_idx] <= pop_data;
    end
  end

  // Load read-mux: youngest pending store beats RAM contents.
  always_comb begin
    readdataM = '0;
    if (load_en) begin
      readdataM = hit ? hit_data : ram_q[word_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] aluoutM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        addr_errorM;
  logic [2:0]  sb_count;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic        err;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  dmem_responder #(
    .ADDR_W   (8),
    .SB_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .memreadM    (memreadM),
    .memwriteM   (memwriteM),
    .aluoutM     (aluoutM),
    .writedataM  (writedataM),
    .readdataM   (readdataM),
    .addr_errorM (addr_errorM),
    .sb_count    (sb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic step(input bit rs, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input string nm, input logic [31:0] erd,
                      input bit eerr, input int ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = rs;
    memreadM   = rd;
    memwriteM  = wr;
    aluoutM    = addr;
    writedataM = data;
    e.name = nm;
    e.rd   = erd;
    e.err  = eerr;
    e.cnt  = ecnt;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (readdataM !== mon_e.rd) begin
        errors++;
        $display("FAIL %s readdataM: got %08h expected %08h", mon_e.name, readdataM, mon_e.rd);
      end
      checks++;
      if (addr_errorM !== mon_e.err) begin
        errors++;
        $display("FAIL %s addr_errorM: got %0b expected %0b", mon_e.name, addr_errorM,
                 mon_e.err);
      end
      checks++;
      if ($isunknown(sb_count) || int'(sb_count) != mon_e.cnt) begin
        errors++;
        $display("FAIL %s sb_count: got %0d expected %0d", mon_e.name, sb_count, mon_e.cnt);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    memreadM   = 1'b0;
    memwriteM  = 1'b0;
    aluoutM    = '0;
    writedataM = '0;
    repeat (2) @(posedge clk);

    step(1, 0, 0, 32'h0,   32'h0,        "reset_idle", 32'h0,        0, 0);
    // Forwarding of a single pending store.
    step(1, 0, 1, 32'h10,  32'hDEADBEEF, "st_10",      32'h0,        0, 0);
    step(1, 1, 0, 32'h10,  32'h0,        "fwd_10",     32'hDEADBEEF, 0, 1);
    step(1, 0, 0, 32'h10,  32'h0,        "noread_0",   32'h0,        0, 1);
    step(1, 1, 0, 32'h10,  32'h0,        "ram_10",     32'hDEADBEEF, 0, 0);
    // Store+load together acts as store only; youngest match wins.
    step(1, 1, 1, 32'h20,  32'h1,        "stld_20a",   32'h0,        0, 0);
    step(1, 1, 1, 32'h20,  32'h2,        "stld_20b",   32'h0,        0, 1);
    step(1, 1, 0, 32'h20,  32'h0,        "young_a",    32'h2,        0, 2);
    step(1, 1, 0, 32'h20,  32'h0,        "young_b",    32'h2,        0, 2);
    step(1, 0, 0, 32'h0,   32'h0,        "drain_20a",  32'h0,        0, 2);
    step(1, 1, 0, 32'h20,  32'h0,        "young_c",    32'h2,        0, 1);
    step(1, 0, 0, 32'h0,   32'h0,        "drain_20b",  32'h0,        0, 1);
    step(1, 1, 0, 32'h20,  32'h0,        "ram_20",     32'h2,        0, 0);
    // Fill to depth, fifth store forces a drain.
    step(1, 1, 1, 32'h0,   32'hA0,       "fill0",      32'h0,        0, 0);
    step(1, 1, 1, 32'h4,   32'hA1,       "fill1",      32'h0,        0, 1);
    step(1, 1, 1, 32'h8,   32'hA2,       "fill2",      32'h0,        0, 2);
    step(1, 1, 1, 32'hC,   32'hA3,       "fill3",      32'h0,        0, 3);
    step(1, 1, 1, 32'h10,  32'hA4,       "fill4_full", 32'h0,        0, 4);
    step(1, 0, 0, 32'h0,   32'h0,        "sat4",       32'h0,        0, 4);
    step(1, 0, 0, 32'h0,   32'h0,        "drain3",     32'h0,        0, 3);
    step(1, 0, 0, 32'h0,   32'h0,        "drain2",     32'h0,        0, 2);
    step(1, 0, 0, 32'h0,   32'h0,        "drain1",     32'h0,        0, 1);
    step(1, 0, 0, 32'h0,   32'h0,        "empty",      32'h0,        0, 0);
    step(1, 1, 0, 32'h0,   32'h0,        "ram_w0",     32'hA0,       0, 0);
    step(1, 1, 0, 32'h4,   32'h0,        "ram_w1",     32'hA1,       0, 0);
    step(1, 1, 0, 32'h8,   32'h0,        "ram_w2",     32'hA2,       0, 0);
    step(1, 1, 0, 32'hC,   32'h0,        "ram_w3",     32'hA3,       0, 0);
    step(1, 1, 0, 32'h10,  32'h0,        "ram_w4",     32'hA4,       0, 0);
    // Misaligned accesses have no effect.
    step(1, 1, 1, 32'h8,   32'h77,       "st_8",       32'h0,        0, 0);
    step(1, 1, 0, 32'h6,   32'h0,        "mis_ld_6",   32'h0,        1, 1);
    step(1, 1, 1, 32'h3,   32'h55,       "mis_st_3",   32'h0,        1, 1);
    step(1, 1, 0, 32'h8,   32'h0,        "after_mis",  32'h77,       0, 1);
    step(1, 0, 0, 32'h0,   32'h0,        "drain_8",    32'h0,        0, 1);
    step(1, 1, 0, 32'h0,   32'h0,        "w0_intact",  32'hA0,       0, 0);
    // Reset discards pending stores; RAM keeps earlier contents.
    step(1, 1, 1, 32'h0,   32'hB0,       "pend0",      32'h0,        0, 0);
    step(1, 1, 1, 32'h4,   32'hB1,       "pend1",      32'h0,        0, 1);
    step(1, 1, 1, 32'h8,   32'hB2,       "pend2",      32'h0,        0, 2);
    step(0, 0, 1, 32'hC,   32'hBAD,      "rst_cycle",  32'h0,        0, 3);
    step(1, 0, 0, 32'h0,   32'h0,        "post_rst",   32'h0,        0, 0);
    step(1, 1, 0, 32'h0,   32'h0,        "keep_w0",    32'hA0,       0, 0);
    step(1, 1, 0, 32'h4,   32'h0,        "keep_w1",    32'hA1,       0, 0);
    step(1, 1, 0, 32'h8,   32'h0,        "keep_w2",    32'h77,       0, 0);
    step(1, 1, 0, 32'hC,   32'h0,        "keep_w3",    32'hA3,       0, 0);
    // Address wrap; push and drain in one cycle.
    step(1, 0, 1, 32'h400, 32'hCAFE0400, "st_400",     32'h0,        0, 0);
    step(1, 0, 1, 32'h404, 32'h11,       "st_404",     32'h0,        0, 1);
    step(1, 0, 0, 32'h0,   32'h0,        "drain_404",  32'h0,        0, 1);
    step(1, 1, 0, 32'h0,   32'h0,        "alias_w0",   32'hCAFE0400, 0, 0);
    step(1, 1, 0, 32'h404, 32'h0,        "alias_404",  32'h11,       0, 0);
    step(1, 1, 0, 32'h4,   32'h0,        "alias_w1",   32'h11,       0, 0);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
